// File: rtl/button_debounce_if.sv
// Signal bundle between the raw push-button pin, its debouncer and the downstream consumers.
// No valid/ready handshake here: btn_raw is a free-running level and every output is a registered level or one-cycle strobe.
interface button_debounce_if;
  logic       btn_raw;
  logic       btn_clean;
  logic       press;
  logic       release_strobe;
  logic       long_press;
  logic [1:0] dbg_state;

  modport master (
    output btn_raw,
    input  btn_clean, press, release_strobe, long_press, dbg_state
  );

  modport slave (
    input  btn_raw,
    output btn_clean, press, release_strobe, long_press, dbg_state
  );
endinterface

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stability-counter debounce for one push-button.
// Produces an active-low clean level and press/release/long-press strobes.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES   = 270000,
  parameter int LONG_PRESS_CYCLES = 27000000,
  parameter int ACTIVE_LOW        = 1
) (
  input logic               clk,
  input logic               rst,
  button_debounce_if.slave  bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic           AL     = (ACTIVE_LOW != 0);
  localparam logic [DW-1:0]  D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]  H_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0]  H_MAX  = HW'(LONG_PRESS_CYCLES);

  typedef enum logic [1:0] {
    S_RELEASED = 2'd0,
    S_PRESSED  = 2'd1,
    S_HELD     = 2'd2
  } state_t;

  logic          sync1, sync2;
  logic          pressed_s;
  logic          accepted;
  logic [DW-1:0] deb_cnt;
  logic          mismatch, accept_fire, accept_press, accept_release;

  state_t        state, state_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic          clean_q, clean_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;

  // Sync flops reset to the released pin level so a held button is seen as a new press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= AL;
      sync2 <= AL;
    end else begin
      sync1 <= bus.btn_raw;
      sync2 <= sync1;
    end
  end

  assign pressed_s      = sync2 ^ AL;
  assign mismatch       = (pressed_s != accepted);
  assign accept_fire    = mismatch && (deb_cnt == D_LAST);
  assign accept_press   = accept_fire && pressed_s;
  assign accept_release = accept_fire && !pressed_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accepted <= 1'b0;
      deb_cnt  <= '0;
    end else if (!mismatch) begin
      deb_cnt  <= '0;
    end else if (accept_fire) begin
      accepted <= pressed_s;
      deb_cnt  <= '0;
    end else begin
      deb_cnt  <= deb_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_RELEASED;
      hold_cnt <= '0;
      clean_q  <= 1'b1;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state    <= state_d;
      hold_cnt <= hold_d;
      clean_q  <= clean_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      long_q   <= long_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_RELEASED: if (accept_press) state_d = S_PRESSED;
      S_PRESSED: begin
        if (accept_release)          state_d = S_RELEASED;
        else if (hold_cnt == H_LAST) state_d = S_HELD;
      end
      S_HELD:     if (accept_release) state_d = S_RELEASED;
      default:    state_d = S_RELEASED;
    endcase
  end

  // Release takes priority over a long-press that would fire on the same edge.
  always_comb begin
    hold_d  = hold_cnt;
    clean_d = clean_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    case (state)
      S_RELEASED: begin
        if (accept_press) begin
          clean_d = 1'b0;
          press_d = 1'b1;
          hold_d  = '0;
        end
      end
      S_PRESSED: begin
        if (accept_release) begin
          clean_d = 1'b1;
          rel_d   = 1'b1;
        end else if (hold_cnt == H_LAST) begin
          long_d  = 1'b1;
        end else if (hold_cnt != H_MAX) begin
          hold_d  = hold_cnt + 1'b1;
        end
      end
      S_HELD: begin
        if (accept_release) begin
          clean_d = 1'b1;
          rel_d   = 1'b1;
        end
      end
      default: clean_d = 1'b1;
    endcase
  end

  assign bus.btn_clean      = clean_q;
  assign bus.press          = press_q;
  assign bus.release_strobe = rel_q;
  assign bus.long_press     = long_q;
  assign bus.dbg_state      = state;

endmodule
